ps2_rx_ctrl: RTL and testbench
==============================

# ps2_rx_ctrl

PS/2 device-to-host receive controller. Synchronizes and filters the PS/2 clock and data lines, then steps an 11-bit frame FSM: start, 8 data bits LSB first, odd parity, stop. It sequences the shift register and the data holding register, and presents each received byte to the keyboard decode logic through a valid/ack holding register with overrun detection.

## Interface
- SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data (≥2)
- FILTER_LEN, 4, consecutive equal synchronized samples required before the filtered ps2_clk changes (≥1)
- TIMEOUT_CYCLES, 5000, system cycles without a ps2_clk falling edge before a partial frame is aborted (≥2)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- rx_ack  in  1  consumer accepts rx_data; ignored when rx_valid=0
- rx_data  out  8  last good byte; reset 0x00
- rx_valid  out  1  rx_data holds an unconsumed byte; reset 0
- overrun  out  1  sticky: a good frame was dropped because rx_valid was set; reset 0
- parity_err  out  1  one-cycle pulse on a parity mismatch; reset 0
- frame_err  out  1  one-cycle pulse on a bad start, bad stop or timeout; reset 0

## Operation
- Filtered ps2_clk resets to 1. fall_stb is a one-cycle strobe on each filtered 1→0 transition. ps2_data passes through SYNC_STAGES flops only and is sampled when fall_stb is high.
- States: IDLE, DATA, PARITY, STOP.
- IDLE, on fall_stb:
  - data=0 → DATA, bit_cnt=0.
  - data=1 → stay in IDLE and pulse frame_err.
- DATA, on fall_stb: shift the sampled bit into shreg[7] and shift right (LSB first), bit_cnt+1. When bit_cnt=7 → PARITY.
- PARITY, on fall_stb: par_ok = (^shreg ^ data)==1. → STOP.
- STOP, on fall_stb, then → IDLE:
  - data=0 → frame_err pulse. The stop check takes priority; no parity_err is raised.
  - data=1, !par_ok → parity_err pulse.
  - data=1, par_ok → commit.
- Commit:
  - rx_valid=0, or rx_ack this cycle: rx_data←shreg, rx_valid←1.
  - Otherwise: byte dropped, rx_data unchanged, overrun←1.
- rx_ack with rx_valid=1 and no commit in the same cycle clears rx_valid and overrun. A commit and rx_ack in the same cycle loads the new byte, keeps rx_valid=1, and clears overrun.
- Timeout: the counter clears on fall_stb and in IDLE. In any other state, when it reaches TIMEOUT_CYCLES-1 the FSM goes to IDLE, frame_err pulses and shreg is discarded. The counter is $clog2(TIMEOUT_CYCLES) bits wide and saturates.
- Reset mid-frame returns everything to its reset values. A partially received frame is lost, and the next start bit begins a new frame.

## Timing
- fall_stb asserts SYNC_STAGES+FILTER_LEN+1 cycles after the ps2_clk pin falls.
- State, shreg, bit_cnt and flags update on the clk edge where fall_stb=1; the outputs are visible the next cycle.
- rx_valid rises one cycle after the STOP-bit fall_stb. Latency from the STOP-bit pin edge to rx_valid is SYNC_STAGES+FILTER_LEN+2 cycles.
- rx_valid stays high until an rx_ack cycle. It falls on the cycle after that ack.
- parity_err and frame_err are exactly one cycle wide.
- Glitches on ps2_clk shorter than FILTER_LEN cycles produce no fall_stb.

## Configuration
- PS2_RX_PARITY_CHECK_EN defined: parity is checked as described above.
- PS2_RX_PARITY_CHECK_EN undefined:
  - The PARITY state still consumes the bit, but par_ok is forced to 1.
  - parity_err is tied to 0.
  - A frame with a bad parity bit and a good stop bit is committed.

## Structure
- Package ps2_pkg holds:
  - the state enum typedef ps2_rx_state_t;
  - PS2_DATA_BITS=8;
  - PS2_FRAME_BITS=11;
  - PS2_DEFAULT_TIMEOUT=5000.
- One sub-module, ps2_clk_filter: the synchronizer, glitch filter and fall_stb generator for ps2_clk, parameterized by SYNC_STAGES and FILTER_LEN.
- The FSM, shift register, timeout counter and holding register stay in ps2_rx_ctrl.

## Test plan
- Frame 0x1C (parity 0, stop 1), no ack → rx_data=0x1C, rx_valid=1 held for 100 cycles, no error pulses. Then rx_ack → rx_valid=0.
- Frame 0xF0 with parity bit 0 → single-cycle parity_err, rx_valid stays 0. With the macro undefined → rx_data=0xF0, rx_valid=1.
- Frame 0x1C with stop bit 0 → single-cycle frame_err, no parity_err, rx_valid stays 0.
- Frames 0xE0 then 0x75 with no ack → rx_data=0xE0, overrun=1. Then rx_ack → rx_valid=0, overrun=0. Also: commit coinciding with ack → new byte loaded, rx_valid stays 1.
- TIMEOUT_CYCLES=50: start plus 4 data bits, then idle for 50 cycles → frame_err pulse, FSM in IDLE. Next frame 0x29 → rx_data=0x29.
- FILTER_LEN=4: 2-cycle low glitch on ps2_clk → no bit shifted. Also: rst_n low mid-frame → all outputs at reset values, next frame 0x1C received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS       = 8;
  localparam int unsigned PS2_FRAME_BITS      = 11;
  localparam int unsigned PS2_DEFAULT_TIMEOUT = 5000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_rx_state_t;

endpackage

// File: rtl/ps2_rx_ctrl_clk_filter.sv
// ps2_clk synchronizer, glitch filter and one-cycle falling-edge strobe.
module ps2_clk_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  output logic fall_stb
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt_q;
  logic                   filt_prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Filtered level follows the synchronized line only after FILTER_LEN equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      cnt_q       <= '0;
      fall_stb    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ps2_clk};
      filt_prev_q <= filt_q;
      fall_stb    <= filt_prev_q & ~filt_q;
      if (sync_out != filt_q) begin
        if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
          filt_q <= sync_out;
          cnt_q  <= '0;
        end else begin
          cnt_q  <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: frame FSM, shift/holding registers, timeout.
// Define PS2_RX_PARITY_CHECK_EN to enable odd-parity checking.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = PS2_DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rx_ack,
  output logic [PS2_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     overrun,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

  ps2_rx_state_t            state;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic [2:0]               bit_cnt;
  logic                     par_ok;
  logic [TMO_W-1:0]         tmo_cnt;
  logic [SYNC_STAGES-1:0]   data_sync_q;
  logic                     data_s;
  logic                     fall_stb;

  ps2_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .fall_stb (fall_stb)
  );

  // Data line is only synchronized; it is sampled well after it settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_sync_q <= '1;
    else        data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
  end

  assign data_s = data_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_ok     <= 1'b0;
      tmo_cnt    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      if (fall_stb) begin
        tmo_cnt <= '0;
        unique case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            shreg   <= {data_s, shreg[PS2_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
            par_ok <= (^shreg) ^ data_s;
`else
            par_ok <= 1'b1;
`endif
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!data_s) begin
              frame_err <= 1'b1;
            end else if (!par_ok) begin
`ifdef PS2_RX_PARITY_CHECK_EN
              parity_err <= 1'b1;
`endif
            end else if (!rx_valid || rx_ack) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state == ST_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        // Stalled partial frame: abort and wait for a fresh start bit.
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        shreg     <= '0;
        bit_cnt   <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed self-checking bench for ps2_rx_ctrl (SYNC=2, FILTER=4, TIMEOUT=50).
module tb_ps2_rx_ctrl;

  localparam int unsigned HALF = 10;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ack   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       parity_err;
  logic       frame_err;

  int errors   = 0;
  int checks   = 0;
  int pe_total = 0;
  int fe_total = 0;
  int lat      = -1;
  int pe0, fe0, bad;

  ps2_rx_ctrl #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .overrun    (overrun),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Count error-pulse cycles; one pulse of one cycle adds exactly 1.
  always @(negedge clk) begin
    if (parity_err) pe_total++;
    if (frame_err)  fe_total++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int ack_at, input bit track);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF - 1) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (track && lat < 0 && rx_valid) lat = i;
      rx_ack = (ack_at == i);
    end
    rx_ack  = 1'b0;
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                            input int ack_at);
    lat = -1;
    send_bit(1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 0, 1'b0);
    send_bit((~^d) ^ par_flip, 0, 1'b0);
    send_bit(stop, ack_at, 1'b1);
    wait_cyc(4);
  endtask

  task automatic ack_byte();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    wait_cyc(5);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Good frame, no ack: latency, hold, then ack.
    pe0 = pe_total; fe0 = fe_total;
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    check("good_data", 32'(rx_data), 32'h1C);
    check("good_valid", 32'(rx_valid), 32'h1);
    check("good_latency", 32'(lat), 32'd8);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!rx_valid || rx_data != 8'h1C) bad++;
    end
    check("good_hold100", 32'(bad), 32'd0);
    check("good_no_perr", 32'(pe_total - pe0), 32'd0);
    check("good_no_ferr", 32'(fe_total - fe0), 32'd0);
    ack_byte();
    check("ack_clears_valid", 32'(rx_valid), 32'h0);

    // Bad parity bit, good stop.
    pe0 = pe_total; fe0 = fe_total;
    send_frame(8'hF0, 1'b1, 1'b1, 0);
    check("par_no_ferr", 32'(fe_total - fe0), 32'd0);
`ifdef PS2_RX_PARITY_CHECK_EN
    check("par_perr_pulse", 32'(pe_total - pe0), 32'd1);
    check("par_valid", 32'(rx_valid), 32'h0);
`else
    check("par_perr_tied", 32'(pe_total - pe0), 32'd0);
    check("par_data", 32'(rx_data), 32'hF0);
    check("par_valid", 32'(rx_valid), 32'h1);
    ack_byte();
`endif

    // Bad stop bit wins over anything else.
    pe0 = pe_total; fe0 = fe_total;
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    check("stop_ferr_pulse", 32'(fe_total - fe0), 32'd1);
    check("stop_no_perr", 32'(pe_total - pe0), 32'd0);
    check("stop_valid", 32'(rx_valid), 32'h0);

    // Overrun, then ack clears both.
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'h75, 1'b0, 1'b1, 0);
    check("ovr_data", 32'(rx_data), 32'hE0);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    ack_byte();
    check("ovr_ack_valid", 32'(rx_valid), 32'h0);
    check("ovr_ack_flag", 32'(overrun), 32'h0);

    // Commit coinciding with ack (ack sampled on the commit edge).
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0);
    check("coin_pre_ovr", 32'(overrun), 32'h1);
    send_frame(8'h33, 1'b0, 1'b1, 7);
    check("coin_data", 32'(rx_data), 32'h33);
    check("coin_valid", 32'(rx_valid), 32'h1);
    check("coin_ovr_clr", 32'(overrun), 32'h0);
    ack_byte();

    // Timeout after start + 4 data bits.
    fe0 = fe_total;
    send_bit(1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0);
    wait_cyc(80);
    check("tmo_ferr_pulse", 32'(fe_total - fe0), 32'd1);
    check("tmo_valid", 32'(rx_valid), 32'h0);
    send_frame(8'h29, 1'b0, 1'b1, 0);
    check("tmo_next_data", 32'(rx_data), 32'h29);
    check("tmo_next_valid", 32'(rx_valid), 32'h1);
    check("tmo_next_no_ferr", 32'(fe_total - fe0), 32'd1);
    ack_byte();

    // 2-cycle glitches on ps2_clk, with data high then low.
    fe0 = fe_total;
    @(negedge clk); ps2_clk = 1'b0;
    wait_cyc(2);    ps2_clk = 1'b1;
    wait_cyc(20);
    check("glitch_hi_no_ferr", 32'(fe_total - fe0), 32'd0);
    ps2_data = 1'b0;
    wait_cyc(10);   ps2_clk = 1'b0;
    wait_cyc(2);    ps2_clk = 1'b1;
    wait_cyc(10);   ps2_data = 1'b1;
    wait_cyc(20);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    check("glitch_data", 32'(rx_data), 32'h1C);
    check("glitch_no_ferr", 32'(fe_total - fe0), 32'd0);
    ack_byte();

    // Reset in the middle of a frame with valid and overrun set.
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'h75, 1'b0, 1'b1, 0);
    send_bit(1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    wait_cyc(3);
    check("mid_rst_data", 32'(rx_data), 32'h00);
    check("mid_rst_valid", 32'(rx_valid), 32'h0);
    check("mid_rst_ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    wait_cyc(5);
    pe0 = pe_total; fe0 = fe_total;
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    check("post_rst_data", 32'(rx_data), 32'h1C);
    check("post_rst_valid", 32'(rx_valid), 32'h1);
    check("post_rst_no_ferr", 32'(fe_total - fe0), 32'd0);
    check("post_rst_no_perr", 32'(pe_total - pe0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
